fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the fetch stage of the 64-bit pipeline. Owns the PC and drives a variable-latency instruction memory through a req/ack handshake. Applies branch redirects (PCSrc_F/PCBranch_F), including redirects that arrive while a request is outstanding. Holds one fetched instruction in a single-entry output buffer until decode accepts it.

## Interface
Parameters:
- RESET_PC, 64'h0, PC of the first fetch after reset.
- INSTR_W, 32, instruction width in bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  reset is asynchronous and active-high.
- PCSrc_F  in  1  redirect request; one-cycle pulse, higher priority than all other events.
- PCBranch_F  in  64  redirect target, sampled when PCSrc_F=1.
- stall_D  in  1  decode not ready; blocks consumption of the buffered instruction.
- imem_req  out  1  memory request valid.
- imem_addr_F  out  64  request address; stable while imem_req=1.
- imem_ack  in  1  response valid; completes the outstanding request.
- imem_rdata  in  INSTR_W  instruction, valid when imem_ack=1.
- instr_valid_F  out  1  output buffer holds a live instruction.
- instr_F  out  INSTR_W  buffered instruction.
- pc_F  out  64  PC of instr_F.

## Operation
- States: IDLE, REQ, HOLD, DROP. Reset state is IDLE.
- Internal registers: pc (address of the next or current request), tgt (pending redirect target).
- IDLE: lasts one cycle. Next state is REQ with pc=RESET_PC, or REQ with pc=PCBranch_F if PCSrc_F=1.
- REQ: imem_req=1, imem_addr_F=pc. Transitions:
  - ack and no redirect: capture imem_rdata into instr_F, set pc_F=pc, go to HOLD.
  - ack and redirect: discard the data, set pc=PCBranch_F, stay in REQ.
  - redirect without ack: tgt=PCBranch_F, go to DROP.
  - otherwise: stay in REQ.
- DROP: imem_req=1 with the old address still held. The handshake is never abandoned mid-flight.
  - redirect: tgt=PCBranch_F (latest redirect wins).
  - ack: discard the data, pc=tgt (or PCBranch_F if a redirect arrives the same cycle), go to REQ.
- HOLD: instr_valid_F=1, imem_req=0.
  - redirect: invalidate the buffer, pc=PCBranch_F, go to REQ. The buffered instruction is not consumed, even if stall_D=0.
  - !stall_D and no redirect: instruction consumed; pc=pc_F+4, go to REQ.
  - stall_D and no redirect: hold all outputs unchanged.
- Arithmetic: PC increment is modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0. Targets are not alignment-checked.
- Reset asserted mid-operation: immediately returns to IDLE with reset values. Any in-flight ack is ignored.
- imem_ack outside REQ/DROP is ignored.

## Timing
- Reset values: imem_req=0, imem_addr_F=RESET_PC, instr_valid_F=0, instr_F=0, pc_F=RESET_PC, state IDLE.
- All outputs are registered; there is no combinational path from input to output.
- First request: imem_req rises in the first cycle after reset deasserts.
- Ack in cycle n (REQ) → instr_valid_F=1 in cycle n+1.
- Consumption in cycle m → next imem_req=1 in cycle m+1.
- Zero-wait memory with no stalls gives a peak throughput of 1 instruction per 2 cycles.
- Redirect latency:
  - Redirect in HOLD or IDLE → target requested the next cycle.
  - Redirect in REQ with no ack → target requested the cycle after the old request's ack.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds two output ports, perf_fetched (32) and perf_dropped (32). Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - perf_fetched increments on each consumption.
  - perf_dropped increments on each discarded ack and each buffer invalidated by a redirect.
- FETCH_CTRL_PERF_EN undefined: no perf ports, no counters. Functional behaviour is identical to the enabled case.

## Structure
- fetch_pkg holds: the fetch_state_t enum (IDLE, REQ, HOLD, DROP), the constant INSTR_BYTES=64'd4, and the constant PERF_W=32.
- PC increment uses one instance of the existing adder sub-module (a=pc_F, b=INSTR_BYTES).
- State register and datapath registers are in a single always_ff with asynchronous reset.

## Test plan
- Reset, then ack on the 3rd REQ cycle with rdata=32'h8B020020 → instr_valid_F=1, instr_F=8B020020, pc_F=0; stall_D=0 → next imem_addr_F=4.
- HOLD with stall_D=1 for 5 cycles → outputs constant, imem_req=0; stall_D=0 → request to pc_F+4.
- REQ at 0x10, PCSrc_F pulse with PCBranch_F=0x100, ack 2 cycles later → data discarded, instr_valid_F stays 0, then imem_req at 0x100.
- Redirect to 0x200 in the same cycle as ack at 0x20 → no instruction delivered; next request at 0x200. Redirect in HOLD → buffer invalidated, request at the target the next cycle.
- pc_F=64'hFFFF_FFFF_FFFF_FFFC consumed → next imem_addr_F=0. Reset asserted while in DROP → state IDLE, all outputs at reset values in the same cycle.
- FETCH_CTRL_PERF_EN defined: 3 consumptions plus 2 discards → perf_fetched=3, perf_dropped=2.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller.
package fetch_pkg;

    // IDLE: post-reset launch, REQ: request in flight, HOLD: buffer full,
    // DROP: request in flight whose response will be squashed by a redirect.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;
    localparam int unsigned PERF_W      = 32;

    // Saturating increment for the event counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/fetch_adder.sv
// Plain modulo-2^W adder used for the sequential PC increment.
module fetch_adder #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    // Carry-out is deliberately dropped so the PC wraps.
    assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: owns the PC, runs the imem req/ack
// handshake, applies redirects and holds one instruction for decode.
// Optional event counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned INSTR_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [63:0]        PCBranch_F,
    input  logic               stall_D,
    output logic               imem_req,
    output logic [63:0]        imem_addr_F,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
`ifdef FETCH_CTRL_PERF_EN
    output logic [PERF_W-1:0]  perf_fetched,
    output logic [PERF_W-1:0]  perf_dropped,
`endif
    output logic               instr_valid_F,
    output logic [INSTR_W-1:0] instr_F,
    output logic [63:0]        pc_F
);

    fetch_state_t        state_q, state_d;
    logic [63:0]         pc_q, pc_d;
    logic [63:0]         tgt_q, tgt_d;
    logic [63:0]         pc_f_q, pc_f_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic                valid_q, valid_d;
    logic                req_q, req_d;
    logic [63:0]         pc_next;
    logic                fetched_ev;
    logic                dropped_ev;

    fetch_adder #(
        .W (64)
    ) u_pc_inc (
        .a_i   (pc_f_q),
        .b_i   (INSTR_BYTES),
        .sum_o (pc_next)
    );

    // Next-state and datapath decode; redirect outranks every other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        pc_f_d     = pc_f_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_d      = req_q;
        fetched_ev = 1'b0;
        dropped_ev = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                pc_d    = PCSrc_F ? PCBranch_F : RESET_PC;
            end
            REQ: begin
                if (imem_ack && !PCSrc_F) begin
                    instr_d = imem_rdata;
                    pc_f_d  = pc_q;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end else if (imem_ack) begin
                    // Response lands together with a redirect: drop it, reissue.
                    pc_d       = PCBranch_F;
                    dropped_ev = 1'b1;
                end else if (PCSrc_F) begin
                    // Cannot abandon the handshake; park the target until ack.
                    tgt_d   = PCBranch_F;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    pc_d       = PCSrc_F ? PCBranch_F : tgt_q;
                    state_d    = REQ;
                    dropped_ev = 1'b1;
                end else if (PCSrc_F) begin
                    tgt_d = PCBranch_F;
                end
            end
            HOLD: begin
                if (PCSrc_F) begin
                    valid_d    = 1'b0;
                    pc_d       = PCBranch_F;
                    req_d      = 1'b1;
                    state_d    = REQ;
                    dropped_ev = 1'b1;
                end else if (!stall_D) begin
                    valid_d    = 1'b0;
                    pc_d       = pc_next;
                    req_d      = 1'b1;
                    state_d    = REQ;
                    fetched_ev = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            pc_f_q  <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pc_f_q  <= pc_f_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr_F   = pc_q;
    assign instr_valid_F = valid_q;
    assign instr_F       = instr_q;
    assign pc_F          = pc_f_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [PERF_W-1:0] fetched_q;
    logic [PERF_W-1:0] dropped_q;

    // Saturating event counters for consumed and discarded instructions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_q <= '0;
            dropped_q <= '0;
        end else begin
            if (fetched_ev) fetched_q <= sat_inc(fetched_q);
            if (dropped_ev) dropped_q <= sat_inc(dropped_q);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_dropped = dropped_q;
`else
    logic unused_ev;
    assign unused_ev = fetched_ev ^ dropped_ev;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized
// traffic, all checked against a transaction-level reference model.
module tb_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic        stall_D;
    logic        imem_req;
    logic [63:0] imem_addr_F;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid_F;
    logic [31:0] instr_F;
    logic [63:0] pc_F;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a started flag, the outstanding request, an optional
    // squash-with-pending-target, and the one-entry buffer.
    bit          m_started;
    bit          m_req;
    bit          m_squash;
    bit          m_buf_v;
    logic [63:0] m_addr;
    logic [63:0] m_tgt;
    logic [63:0] m_buf_pc;
    logic [31:0] m_buf_i;
    int unsigned m_fetched;
    int unsigned m_dropped;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC (RST_PC),
        .INSTR_W  (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .stall_D       (stall_D),
        .imem_req      (imem_req),
        .imem_addr_F   (imem_addr_F),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
`ifdef FETCH_CTRL_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_dropped  (perf_dropped),
`endif
        .instr_valid_F (instr_valid_F),
        .instr_F       (instr_F),
        .pc_F          (pc_F)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_req     = 1'b0;
        m_squash  = 1'b0;
        m_buf_v   = 1'b0;
        m_addr    = RST_PC;
        m_tgt     = RST_PC;
        m_buf_pc  = RST_PC;
        m_buf_i   = '0;
        m_fetched = 0;
        m_dropped = 0;
    endtask

    // One clock edge of behaviour, given the inputs presented on that edge.
    task automatic model_step(input bit redir, input logic [63:0] br, input bit stall,
                              input bit ack, input logic [31:0] rd);
        if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = redir ? br : RST_PC;
        end else if (m_buf_v) begin
            if (redir) begin
                m_buf_v = 1'b0;
                m_req   = 1'b1;
                m_addr  = br;
                m_dropped++;
            end else if (!stall) begin
                m_buf_v = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_buf_pc + 64'd4;
                m_fetched++;
            end
        end else if (m_squash) begin
            if (ack) begin
                m_squash = 1'b0;
                m_addr   = redir ? br : m_tgt;
                m_dropped++;
            end else if (redir) begin
                m_tgt = br;
            end
        end else if (ack && !redir) begin
            m_buf_v  = 1'b1;
            m_buf_i  = rd;
            m_buf_pc = m_addr;
            m_req    = 1'b0;
        end else if (ack) begin
            m_addr = br;
            m_dropped++;
        end else if (redir) begin
            m_squash = 1'b1;
            m_tgt    = br;
        end
    endtask

    task automatic compare_all();
        check_eq("imem_req", imem_req, m_req);
        check_eq("instr_valid_F", instr_valid_F, m_buf_v);
        if (!m_started) begin
            check_eq("rst_addr", imem_addr_F, RST_PC);
            check_eq("rst_instr", instr_F, 32'h0);
            check_eq("rst_pc_F", pc_F, RST_PC);
        end
        if (m_req) check_eq("imem_addr_F", imem_addr_F, m_addr);
        if (m_buf_v) begin
            check_eq("instr_F", instr_F, m_buf_i);
            check_eq("pc_F", pc_F, m_buf_pc);
        end
`ifdef FETCH_CTRL_PERF_EN
        check_eq("perf_fetched", perf_fetched, m_fetched);
        check_eq("perf_dropped", perf_dropped, m_dropped);
`endif
    endtask

    // Present inputs (called right after a falling edge), clock once, check.
    task automatic cycle(input bit redir, input logic [63:0] br, input bit stall,
                         input bit ack, input logic [31:0] rd);
        PCSrc_F    = redir;
        PCBranch_F = br;
        stall_D    = stall;
        imem_ack   = ack;
        imem_rdata = rd;
        @(posedge clk);
        model_step(redir, br, stall, ack, rd);
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset mid-cycle with a stray ack present; outputs must
    // drop to reset values before the next edge.
    task automatic do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        PCSrc_F    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        reset    = 1'b0;
        imem_ack = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        PCSrc_F    = 1'b0;
        PCBranch_F = '0;
        stall_D    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b0;

        // Launch, ack on the third REQ cycle, consume.
        cycle(0, 64'h0, 0, 0, 32'h0);
        check_eq("first_req", imem_req, 1'b1);
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(0, 64'h0, 1, 1, 32'h8B02_0020);
        check_eq("d_instr", instr_F, 32'h8B02_0020);
        check_eq("d_pc", pc_F, 64'h0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 64'h0, 1, 0, 32'h0);
            check_eq("stall_no_req", imem_req, 1'b0);
            check_eq("stall_instr", instr_F, 32'h8B02_0020);
        end
        cycle(0, 64'h0, 0, 0, 32'h0);
        check_eq("seq_addr", imem_addr_F, 64'h4);

        // Redirect in HOLD to 0x10, then redirect to 0x100 while REQ is open.
        cycle(0, 64'h0, 1, 1, 32'h1111_1111);
        cycle(1, 64'h10, 0, 0, 32'h0);
        check_eq("hold_redir_valid", instr_valid_F, 1'b0);
        check_eq("hold_redir_addr", imem_addr_F, 64'h10);
        cycle(1, 64'h100, 0, 0, 32'h0);
        check_eq("drop_addr_held", imem_addr_F, 64'h10);
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(0, 64'h0, 0, 1, 32'h2222_2222);
        check_eq("drop_valid", instr_valid_F, 1'b0);
        check_eq("drop_new_addr", imem_addr_F, 64'h100);

        // Ack+redirect to 0x20, then ack at 0x20 with redirect to 0x200.
        cycle(1, 64'h20, 0, 1, 32'h3333_3333);
        cycle(1, 64'h200, 0, 1, 32'h4444_4444);
        check_eq("ackredir_valid", instr_valid_F, 1'b0);
        check_eq("ackredir_addr", imem_addr_F, 64'h200);

        // PC wrap on consumption.
        cycle(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 32'h0);
        cycle(0, 64'h0, 1, 1, 32'h5555_5555);
        check_eq("wrap_pc_F", pc_F, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle(0, 64'h0, 0, 0, 32'h0);
        check_eq("wrap_addr", imem_addr_F, 64'h0);

        // Reset while in DROP.
        cycle(1, 64'h300, 0, 0, 32'h0);
        do_reset();

        // Three consumptions and two discards.
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(0, 64'h0, 1, 1, 32'hA000_0001);
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(0, 64'h0, 1, 1, 32'hA000_0002);
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(1, 64'h40, 0, 1, 32'hA000_0003);
        cycle(0, 64'h0, 1, 1, 32'hA000_0004);
        cycle(0, 64'h0, 0, 0, 32'h0);
        cycle(1, 64'h80, 0, 0, 32'h0);
        cycle(0, 64'h0, 0, 1, 32'hA000_0005);
`ifdef FETCH_CTRL_PERF_EN
        check_eq("perf_f3", perf_fetched, 32'd3);
        check_eq("perf_d2", perf_dropped, 32'd2);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] br;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                br = {$urandom(), $urandom()};
                if ($urandom_range(0, 3) == 0) br = 64'hFFFF_FFFF_FFFF_FFF0 | (br & 64'hC);
                cycle($urandom_range(0, 9) == 0, br, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 2) == 0, $urandom());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
